rrot_8_pipe: RTL and testbench
==============================

# rrot_8_pipe

Pipelined 8-bit logarithmic right rotator with valid/ready flow control on both sides. It is the inverse-direction companion of the combinational 8-bit left rotator in the barrel-shifter family, so rotating the left rotator's output right by the same select restores the original word. It is built as one registered stage per select bit, giving 1 word/cycle throughput with full backpressure support. It sits between a data producer and any consumer that may stall.

## Interface
Parameters:
- WIDTH, 8, data width; must be a power of two, 2..64.
- SEL_W, $clog2(WIDTH) = 3, select width and pipeline depth. Derived; not overridden.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- rrvalid  in  1  input word valid.
- rrready  out  1  block accepts the input word this cycle.
- rrdata  in  WIDTH  word to rotate.
- rrsel  in  SEL_W  right-rotate amount, 0..WIDTH-1.
- rroutvalid  out  1  rrout holds a valid result.
- rroutready  in  1  consumer accepts rrout this cycle.
- rrout  out  WIDTH  rotated word, equal to {rrdata, rrdata} >> rrsel, truncated to WIDTH.

## Operation
- SEL_W stages, k = 0..SEL_W-1. Stage k rotates its input right by 2^k when select bit k is 1; otherwise it passes the input unchanged.
- Each stage has a registered data word, the remaining select bits, and a valid flag v_k. Stage 0 loads from the ports; the last stage drives rrout and rroutvalid.
- Transfer rule: a word moves into stage k when the upstream is valid and ready_k is true.
  - ready_k = !v_k || ready_{k+1}.
  - ready_SEL_W = rroutready.
  - rrready = ready_0 && !rst.
  - The ready chain is combinational across the stages, so a full pipeline that is draining accepts a new word every cycle.
- When v_k is set and ready_{k+1} is false, stage k holds its data and select bits unchanged.
- Rotation is pure wrap-around. No bits are lost or zero-filled, and rrsel = 0 passes the word through unchanged.
- Words leave in the same order they entered. None are dropped or duplicated.

## Timing
- Reset (sync, rst=1 at a rising edge): all v_k = 0, all stage data = 0, rroutvalid = 0, rrout = 0.
  - rrready = 0 while rst is high. rrvalid is ignored during that cycle.
  - rrready = 1 on the first cycle after rst deasserts, because the pipeline is empty.
- Latency: a word accepted at edge N, into an empty and unstalled pipeline, appears on rrout with rroutvalid = 1 after edge N+SEL_W-1. That is 3 cycles for WIDTH = 8, counting the accept edge.
- Throughput: one word per cycle while rroutready = 1.
- Stall behaviour:
  - While rroutvalid = 1 and rroutready = 0, rrout is stable.
  - Bubbles upstream still collapse, so stages fill.
  - Once all SEL_W stages are valid, rrready = 0.
- Simultaneous drain and fill: when the last stage is drained while stage 0 accepts in the same cycle, both happen and the pipeline stays full.
- Mid-operation reset: all in-flight words are discarded. No partial output appears after rst.
- rrout after a word is consumed with no successor: it keeps the last value, but rroutvalid = 0. Bench checks rrout only when rroutvalid = 1.
- Input contract: rrdata and rrsel are sampled only on an accepting edge (rrvalid && rrready).

## Test plan
- Rotation sweep: rrdata = 0xA5, rrsel = 0..7 back-to-back, rroutready = 1. Expect in order 0xA5, 0xD2, 0x69, 0xB4, 0x5A, 0x2D, 0x96, 0x4B. Each result appears 3 cycles after its accept, one per cycle.
- Inverse check: for all 256 rrdata values and all 8 rrsel values, drive the left-rotated word (rrdata rotated left by rrsel) with the same rrsel. Expect rrout = the original rrdata every time.
- Backpressure:
  - Stream 0x01 with rrsel = 1..6 and hold rroutready = 0.
  - Expect rrready to drop after exactly 3 accepts, and rrout to hold at 0x80 (0x01 rotated right by 1).
  - Release rroutready. Expect 0x80, 0x40, 0x20, 0x10, 0x08, 0x04 in order with no gaps or duplicates.
- Random handshake: randomised rrvalid and rroutready at 50% duty for 10k words, checked against a reference-model queue. Expect order preserved, no loss, and rrout stable across every stall.
- Mid-operation reset: put 3 words in flight, then assert rst for 1 cycle.
  - Next cycle: rroutvalid = 0, rrout = 0, rrready = 1.
  - No stale word emerges in the following 5 cycles.
- Reset during a stall: fill the pipeline with rroutready = 0, then assert rst. Expect all outputs at reset values. rrready = 0 during the rst cycle and 1 afterwards.

Source files
------------

// File: rtl/rrot_8_pipe_if.sv
// Valid/ready bundle for the pipelined right rotator: input word side and rotated output side.
// master drives words and consumer ready; slave is the rotator.
interface rrot_8_pipe_if #(
   parameter int WIDTH = 8,
   parameter int SEL_W = $clog2(WIDTH)
);
   logic             rrvalid;
   logic             rrready;
   logic [WIDTH-1:0] rrdata;
   logic [SEL_W-1:0] rrsel;
   logic             rroutvalid;
   logic             rroutready;
   logic [WIDTH-1:0] rrout;

   modport master (
      output rrvalid, rrdata, rrsel, rroutready,
      input  rrready, rroutvalid, rrout
   );

   modport slave (
      input  rrvalid, rrdata, rrsel, rroutready,
      output rrready, rroutvalid, rrout
   );
endinterface

// File: rtl/rrot_8_pipe.sv
// Pipelined logarithmic right rotator, one registered stage per select bit (latency SEL_W edges).
// Ready ripples combinationally back through the stages, so a stalled pipe fills its bubbles and a draining pipe streams.
module rrot_8_pipe #(
   parameter int  WIDTH = 8,
   localparam int SEL_W = $clog2(WIDTH)
) (
   input logic          clk,
   input logic          rst,
   rrot_8_pipe_if.slave rr
);
   localparam int NSEL = (SEL_W > 1) ? SEL_W - 1 : 1;

   logic [WIDTH-1:0] dat_q [SEL_W];
   logic [WIDTH-1:0] dat_d [SEL_W];
   logic [SEL_W-1:0] sel_q [NSEL];
   logic [SEL_W-1:0] vld_q;
   logic [SEL_W:0]   rdy;

   assign rdy[SEL_W] = rr.rroutready;

   genvar k;
   generate
      for (k = 0; k < SEL_W; k++) begin : g_stg
         localparam int SH = 1 << k;
         logic             up_vld;
         logic             up_bit;
         logic [WIDTH-1:0] up_dat;

         if (k == 0) begin : g_src
            assign up_vld = rr.rrvalid;
            assign up_bit = rr.rrsel[0];
            assign up_dat = rr.rrdata;
         end else begin : g_src
            assign up_vld = vld_q[k-1];
            assign up_bit = sel_q[k-1][k];
            assign up_dat = dat_q[k-1];
         end

         // Low SH bits wrap around to the top.
         assign dat_d[k] = up_bit ? {up_dat[SH-1:0], up_dat[WIDTH-1:SH]} : up_dat;
         assign rdy[k]   = !vld_q[k] || rdy[k+1];

         always_ff @(posedge clk) begin
            if (rst) begin
               vld_q[k] <= 1'b0;
               dat_q[k] <= '0;
            end else if (rdy[k]) begin
               vld_q[k] <= up_vld;
               if (up_vld) begin
                  dat_q[k] <= dat_d[k];
               end
            end
         end

         // The last stage has no later select bits to carry.
         if (k < SEL_W - 1) begin : g_sel
            logic [SEL_W-1:0] sel_in;
            if (k == 0) begin : g_p
               assign sel_in = rr.rrsel;
            end else begin : g_p
               assign sel_in = sel_q[k-1];
            end

            always_ff @(posedge clk) begin
               if (rst) begin
                  sel_q[k] <= '0;
               end else if (rdy[k] && up_vld) begin
                  sel_q[k] <= sel_in;
               end
            end
         end
      end
   endgenerate

   assign rr.rrready    = rdy[0] && !rst;
   assign rr.rroutvalid = vld_q[SEL_W-1];
   assign rr.rrout      = dat_q[SEL_W-1];
endmodule

// File: tb/tb_rrot_8_pipe.sv
// Directed and random stimulus for rrot_8_pipe against a queue-based reference model.
module tb_rrot_8_pipe;
   localparam int WIDTH = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rrot_8_pipe_if #(.WIDTH(WIDTH)) rr ();

   rrot_8_pipe #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .rr  (rr.slave)
   );

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;
   always @(posedge clk) cyc++;

   logic [7:0] exp_q [$];
   int         acc_q [$];
   bit         stalled_prev;
   logic [7:0] held;
   int         n_out;
   bit         acc;

   logic [7:0] sweep_tab [8] = '{8'hA5, 8'hD2, 8'h69, 8'hB4, 8'h5A, 8'h2D, 8'h96, 8'h4B};
   logic [7:0] bp_tab    [6] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] ref_ror(input logic [7:0] d, input int s);
      int w;
      w = int'(d);
      return 8'((w >> s) | (w << (8 - s)));
   endfunction

   function automatic logic [7:0] ref_rol(input logic [7:0] d, input int s);
      int w;
      w = int'(d);
      return 8'((w << s) | (w >> (8 - s)));
   endfunction

   // Inputs are already driven; evaluate both handshakes before the edge, then advance.
   task automatic cycle(input logic [7:0] exp_if_acc, input bit chk_lat);
      int lat;
      @(negedge clk);
      acc = rr.rrvalid && rr.rrready;
      if (stalled_prev) begin
         chk("stall_vld", 32'(rr.rroutvalid), 1);
         chk("stall_dat", 32'(rr.rrout), 32'(held));
      end
      if (rr.rroutvalid && rr.rroutready) begin
         chk("out_pending", 32'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            chk("out_dat", 32'(rr.rrout), 32'(exp_q.pop_front()));
            lat = acc_q.pop_front();
            if (chk_lat) chk("latency", cyc - lat, 3);
            n_out++;
         end
      end
      stalled_prev = rr.rroutvalid && !rr.rroutready;
      held         = rr.rrout;
      if (acc) begin
         exp_q.push_back(exp_if_acc);
         acc_q.push_back(cyc);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int bound, input bit chk_lat);
      int i;
      i = 0;
      rr.rrvalid    = 1'b0;
      rr.rroutready = 1'b1;
      while (exp_q.size() != 0 && i < bound) begin
         cycle(8'h00, chk_lat);
         i++;
      end
      chk("drain_done", exp_q.size(), 0);
   endtask

   task automatic reset_pulse();
      rst        = 1'b1;
      rr.rrvalid = 1'b1;
      @(negedge clk);
      chk("rst_cycle_rdy", 32'(rr.rrready), 0);
      @(posedge clk);
      #1;
      rst          = 1'b0;
      rr.rrvalid   = 1'b0;
      exp_q.delete();
      acc_q.delete();
      stalled_prev = 1'b0;
      @(negedge clk);
      chk("post_rst_vld", 32'(rr.rroutvalid), 0);
      chk("post_rst_dat", 32'(rr.rrout), 0);
      chk("post_rst_rdy", 32'(rr.rrready), 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int k;
      int c;
      int acc_n;

      rst           = 1'b1;
      rr.rrvalid    = 1'b0;
      rr.rrdata     = 8'h00;
      rr.rrsel      = 3'd0;
      rr.rroutready = 1'b1;
      stalled_prev  = 1'b0;
      held          = 8'h00;
      n_out         = 0;
      acc           = 1'b0;

      // Reset state; a word offered while rst is high must be ignored.
      @(posedge clk);
      #1;
      rr.rrvalid = 1'b1;
      rr.rrdata  = 8'hFF;
      rr.rrsel   = 3'd1;
      @(negedge clk);
      chk("rst_rdy", 32'(rr.rrready), 0);
      chk("rst_vld", 32'(rr.rroutvalid), 0);
      chk("rst_dat", 32'(rr.rrout), 0);
      @(posedge clk);
      #1;
      rst        = 1'b0;
      rr.rrvalid = 1'b0;
      @(negedge clk);
      chk("rdy_after_rst", 32'(rr.rrready), 1);
      chk("vld_after_rst", 32'(rr.rroutvalid), 0);
      @(posedge clk);
      #1;

      // Rotation sweep of 0xA5, back to back.
      for (int s = 0; s < 8; s++) begin
         rr.rrvalid = 1'b1;
         rr.rrdata  = 8'hA5;
         rr.rrsel   = 3'(s);
         cycle(sweep_tab[s], 1'b1);
         chk("sweep_acc", 32'(acc), 1);
      end
      drain(20, 1'b1);

      // Inverse of the left rotator over every word and amount.
      rr.rroutready = 1'b1;
      for (int d = 0; d < 256; d++) begin
         for (int s = 0; s < 8; s++) begin
            rr.rrvalid = 1'b1;
            rr.rrdata  = ref_rol(8'(d), s);
            rr.rrsel   = 3'(s);
            cycle(8'(d), 1'b1);
         end
      end
      drain(20, 1'b1);

      // Backpressure: three stages fill, then input stalls.
      rr.rroutready = 1'b0;
      k = 0;
      for (int i = 0; i < 6; i++) begin
         rr.rrvalid = 1'b1;
         rr.rrdata  = 8'h01;
         rr.rrsel   = 3'(k + 1);
         cycle(bp_tab[k], 1'b0);
         if (acc) k++;
      end
      chk("bp_accepts", k, 3);
      chk("bp_rdy", 32'(rr.rrready), 0);
      chk("bp_vld", 32'(rr.rroutvalid), 1);
      chk("bp_hold", 32'(rr.rrout), 32'h80);
      rr.rroutready = 1'b1;
      n_out = 0;
      c     = 0;
      while (n_out < 6 && c < 20) begin
         rr.rrvalid = (k < 6);
         rr.rrdata  = 8'h01;
         rr.rrsel   = 3'(k + 1);
         cycle((k < 6) ? bp_tab[k] : 8'h00, 1'b0);
         if (acc) k++;
         c++;
      end
      chk("bp_outs", n_out, 6);
      chk("bp_no_gap", c, 6);
      chk("bp_q_empty", exp_q.size(), 0);

      // Random handshake on both sides.
      acc_n = 0;
      c     = 0;
      while (acc_n < 10000 && c < 60000) begin
         rr.rrvalid    = 1'($urandom_range(0, 1));
         rr.rrdata     = 8'($urandom);
         rr.rrsel      = 3'($urandom_range(0, 7));
         rr.rroutready = 1'($urandom_range(0, 1));
         cycle(ref_ror(rr.rrdata, int'(rr.rrsel)), 1'b0);
         if (acc) acc_n++;
         c++;
      end
      chk("rand_words", acc_n, 10000);
      drain(40, 1'b0);

      // Mid-operation reset with three words in flight.
      rr.rroutready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rr.rrvalid = 1'b1;
         rr.rrdata  = 8'($urandom);
         rr.rrsel   = 3'($urandom_range(0, 7));
         cycle(ref_ror(rr.rrdata, int'(rr.rrsel)), 1'b0);
      end
      reset_pulse();
      rr.rroutready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cycle(8'h00, 1'b0);
         chk("no_stale", 32'(rr.rroutvalid), 0);
      end

      // Reset while the full pipeline is stalled.
      rr.rroutready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rr.rrvalid = 1'b1;
         rr.rrdata  = 8'($urandom);
         rr.rrsel   = 3'($urandom_range(0, 7));
         cycle(ref_ror(rr.rrdata, int'(rr.rrsel)), 1'b0);
      end
      chk("stall_full_rdy", 32'(rr.rrready), 0);
      chk("stall_full_vld", 32'(rr.rroutvalid), 1);
      reset_pulse();
      drain(10, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
